alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width; only 32 is supported.
REQ-002 clock  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request; sampled only while busy is low.
REQ-005 op  input  5  operation code: 0 OR, 1 AND, 2 ADD, 3 SUB, 4 NEG, 5 SHR, 6 SHL, 7 MUL, 8 DIV; others are treated as AND.
REQ-006 a  input  WIDTH  operand A, captured on the accepting edge.
REQ-007 b  input  WIDTH  operand B, captured on the accepting edge.
REQ-008 busy  output  1  high while an operation is in progress.
REQ-009 done  output  1  one-cycle completion pulse.
REQ-010 result_lo  output  WIDTH  low result word, or quotient.
REQ-011 result_hi  output  WIDTH  high product word, or remainder; zero for ops 0-6.
REQ-012 div_by_zero  output  1  valid with done; high only for DIV with b==0.

Function
REQ-013 States SHALL be IDLE, MUL_ITER, DIV_ITER and DONE; busy = (state is MUL_ITER or DIV_ITER).
REQ-014 Accepting edge: start high at a rising edge in IDLE or DONE; start at any other time SHALL be ignored, with no queuing.
REQ-015 Ops 0-6 and ops >8 SHALL write results on the accepting edge and go to DONE (latency 1 edge).
REQ-016 Op semantics: OR/AND bitwise; ADD/SUB mod 2^32, carry discarded; NEG = two's complement of a; SHR/SHL = logical shift of a by one bit.
REQ-017 MUL: unsigned 32x32->64 shift-add multiply, one iteration per edge for 32 edges; enters DONE on edge N+32; result_hi:result_lo = a*b.
REQ-018 DIV: unsigned restoring divide, 32 iterations, same timing as MUL; result_lo = a/b and result_hi = a%b.
REQ-019 DIV with b==0 SHALL complete in 1 edge: result_lo = all ones, result_hi = a, div_by_zero = 1.
REQ-020 A 6-bit iteration counter SHALL count 0..31; the iteration that sees count 31 SHALL move the block to DONE, and the counter SHALL clear on accept.
REQ-021 done SHALL be high for exactly the one cycle spent in DONE.
REQ-022 DONE SHALL go to IDLE on the next edge unless start is high, in which case that edge is a new accepting edge (back-to-back ops).
REQ-023 result_lo, result_hi and div_by_zero SHALL hold their values until the next completion, including while the next op iterates.
REQ-024 Changes on a and b after the accepting edge SHALL NOT affect the current result.

Reset
REQ-025 reset SHALL override start at the same edge.
REQ-026 On reset the block SHALL go to IDLE with busy=0, done=0, result_lo=0, result_hi=0, div_by_zero=0 and counter=0.
REQ-027 A reset during MUL_ITER or DIV_ITER SHALL abort the operation; no done pulse follows.

Structure
REQ-028 The op-code constants, the state encoding and WIDTH SHALL live in a shared package, alu_pkg.
REQ-029 The iterative multiply/divide datapath (accumulator, shift register, counter) SHALL be one sub-module, mul_div_iter; the FSM and single-cycle ops stay in alu_sequencer.

Verification
REQ-030 Single-cycle op: op=2, a=5, b=7 -> done high in the cycle after accept, result_lo=12, result_hi=0, busy never high.
REQ-031 Multiply: op=7, a=0xFFFFFFFF, b=2 -> busy high for 32 cycles; done after edge N+32; result_hi=0x00000001, result_lo=0xFFFFFFFE.
REQ-032 Divide: op=8, a=100, b=7 -> done after 32 iterations, result_lo=14, result_hi=2, div_by_zero=0.
REQ-033 Divide by zero: op=8, a=0x1234, b=0 -> done after 1 edge, result_lo=0xFFFFFFFF, result_hi=0x1234, div_by_zero=1.
REQ-034 Ignored start: a second start (op=2) while a MUL is at iteration 5 is ignored; only the MUL completes, with the correct product.
REQ-035 Reset abort: reset at MUL iteration 10 -> next cycle state IDLE, all outputs 0, no done pulse; a following ADD 3+4 returns 7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: data width, op-code values,
// FSM state encoding and the single-cycle operation function.
package alu_pkg;

    localparam int WIDTH  = 32;
    localparam int OP_W   = 5;
    localparam int ITER_W = 6;

    localparam logic [OP_W-1:0] OP_OR  = 5'd0;
    localparam logic [OP_W-1:0] OP_AND = 5'd1;
    localparam logic [OP_W-1:0] OP_ADD = 5'd2;
    localparam logic [OP_W-1:0] OP_SUB = 5'd3;
    localparam logic [OP_W-1:0] OP_NEG = 5'd4;
    localparam logic [OP_W-1:0] OP_SHR = 5'd5;
    localparam logic [OP_W-1:0] OP_SHL = 5'd6;
    localparam logic [OP_W-1:0] OP_MUL = 5'd7;
    localparam logic [OP_W-1:0] OP_DIV = 5'd8;

    // Counter value of the final multiply/divide iteration.
    localparam logic [ITER_W-1:0] LAST_ITER = 6'd31;

    localparam logic [WIDTH-1:0] ONE_W = 32'd1;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MUL_ITER = 2'd1,
        ST_DIV_ITER = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    // Result of the operations that complete on the accepting edge.
    // Unknown op-codes (and MUL/DIV, which never use this path) fall back to AND.
    function automatic logic [WIDTH-1:0] single_cycle_result(
        input logic [OP_W-1:0]  op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_NEG:  r = ~a + ONE_W;
            OP_SHR:  r = {1'b0, a[WIDTH-1:1]};
            OP_SHL:  r = {a[WIDTH-2:0], 1'b0};
            default: r = a & b;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative datapath shared by unsigned multiply and restoring divide.
// acc holds the product high word / partial remainder, shreg holds the
// multiplier (becoming the product low word) / dividend (becoming the
// quotient), opnd holds the multiplicand / divisor. One step per edge.
module mul_div_iter
    import alu_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              is_div_i,
    input  logic              step_i,
    input  logic [WIDTH-1:0]  a_i,
    input  logic [WIDTH-1:0]  b_i,
    output logic              last_o,
    output logic [WIDTH-1:0]  hi_next_o,
    output logic [WIDTH-1:0]  lo_next_o
);

    logic [WIDTH-1:0]  acc_q,   acc_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [WIDTH-1:0]  opnd_q,  opnd_d;
    logic [ITER_W-1:0] cnt_q,   cnt_d;
    logic              is_div_q, is_div_d;

    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_shift;
    logic [WIDTH-1:0]  div_diff;
    logic              div_fits;
    logic [WIDTH-1:0]  step_hi;
    logic [WIDTH-1:0]  step_lo;

    // One shift-add or restoring-subtract step computed from the current registers.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {acc_q, shreg_q[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opnd_q});
        // When the divisor fits the difference is below 2^WIDTH, so the
        // truncated subtraction is exact.
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        if (is_div_q) begin
            step_hi = div_fits ? div_diff : div_shift[WIDTH-1:0];
            step_lo = {shreg_q[WIDTH-2:0], div_fits};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], shreg_q[WIDTH-1:1]};
        end
    end

    // Load operands on accept, otherwise advance one step while iterating.
    always_comb begin
        acc_d    = acc_q;
        shreg_d  = shreg_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        if (load_i) begin
            acc_d    = '0;
            shreg_d  = is_div_i ? a_i : b_i;
            opnd_d   = is_div_i ? b_i : a_i;
            cnt_d    = '0;
            is_div_d = is_div_i;
        end else if (step_i) begin
            acc_d   = step_hi;
            shreg_d = step_lo;
            cnt_d   = cnt_q + 6'd1;
        end
    end

    // Datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q    <= '0;
            shreg_q  <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            shreg_q  <= shreg_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
        end
    end

    // The final step's values go straight to the result registers upstream.
    always_comb begin
        last_o    = step_i && (cnt_q == LAST_ITER);
        hi_next_o = step_hi;
        lo_next_o = step_lo;
    end

endmodule

// File: rtl/alu_sequencer.sv
// ALU sequencer: single-cycle logic/arithmetic ops plus 32-step unsigned
// multiply and divide. Handshake: start is sampled only while the FSM is in
// IDLE or DONE; that edge captures op/a/b, and done pulses for exactly one
// cycle when the result registers have been updated.
module alu_sequencer #(
    parameter int WIDTH = alu_pkg::WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [4:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [WIDTH-1:0]     result_lo,
    output logic [WIDTH-1:0]     result_hi,
    output logic                 div_by_zero,
    output alu_pkg::state_t      state_dbg
);

    import alu_pkg::*;

    state_t state_q, state_d;

    logic [WIDTH-1:0] res_lo_q, res_lo_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             dbz_q, dbz_d;

    logic             accept;
    logic             is_mul;
    logic             is_div;
    logic             b_zero;
    logic             iter_load;
    logic             iter_step;
    logic             iter_last;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    // Decode of the request presented at this edge.
    always_comb begin
        accept    = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        is_mul    = (op == OP_MUL);
        is_div    = (op == OP_DIV);
        b_zero    = (b == '0);
        iter_load = accept && (is_mul || (is_div && !b_zero));
        iter_step = (state_q == ST_MUL_ITER) || (state_q == ST_DIV_ITER);
    end

    mul_div_iter u_iter (
        .clk_i     (clock),
        .rst_i     (reset),
        .load_i    (iter_load),
        .is_div_i  (is_div),
        .step_i    (iter_step),
        .a_i       (a),
        .b_i       (b),
        .last_o    (iter_last),
        .hi_next_o (iter_hi),
        .lo_next_o (iter_lo)
    );

    // State register; reset wins over any request at the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (is_mul) begin
                        state_d = ST_MUL_ITER;
                    end else if (is_div && !b_zero) begin
                        state_d = ST_DIV_ITER;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_MUL_ITER, ST_DIV_ITER: begin
                if (iter_last) begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state.
    always_comb begin
        busy      = (state_q == ST_MUL_ITER) || (state_q == ST_DIV_ITER);
        done      = (state_q == ST_DONE);
        state_dbg = state_q;
    end

    // Result update: single-cycle ops and divide-by-zero on accept, iterative
    // ops on their last step; values hold otherwise.
    always_comb begin
        res_lo_d = res_lo_q;
        res_hi_d = res_hi_q;
        dbz_d    = dbz_q;
        if (accept && !iter_load) begin
            if (is_div) begin
                res_lo_d = '1;
                res_hi_d = a;
                dbz_d    = 1'b1;
            end else begin
                res_lo_d = single_cycle_result(op, a, b);
                res_hi_d = '0;
                dbz_d    = 1'b0;
            end
        end else if (iter_last) begin
            res_lo_d = iter_lo;
            res_hi_d = iter_hi;
            dbz_d    = 1'b0;
        end
    end

    // Result registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            res_lo_q <= '0;
            res_hi_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            res_lo_q <= res_lo_d;
            res_hi_q <= res_hi_d;
            dbz_q    <= dbz_d;
        end
    end

    assign result_lo   = res_lo_q;
    assign result_hi   = res_hi_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: expected {div_by_zero, hi, lo}
// words are queued when an op is issued and compared when done pulses.
module tb_alu_sequencer;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  op    = '0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        div_by_zero;
    state_t      state_dbg;

    int          n_total = 0;
    int          n_bad   = 0;
    logic [64:0] exp_q[$];
    logic [64:0] last_res = '0;
    logic [64:0] mon_e;

    alu_sequencer #(.WIDTH(32)) dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .result_lo   (result_lo),
        .result_hi   (result_hi),
        .div_by_zero (div_by_zero),
        .state_dbg   (state_dbg)
    );

    // clock / watchdog
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [64:0] act, input logic [64:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // reference model: {div_by_zero, result_hi, result_lo}
    function automatic logic [64:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        logic [31:0] r;
        case (o)
            5'd0: r = x | y;
            5'd2: r = x + y;
            5'd3: r = x - y;
            5'd4: r = 32'd0 - x;
            5'd5: r = x >> 1;
            5'd6: r = x << 1;
            5'd7: begin
                p = {32'd0, x} * {32'd0, y};
                return {1'b0, p};
            end
            5'd8: begin
                if (y == 32'd0) return {1'b1, x, 32'hFFFF_FFFF};
                return {1'b0, x % y, x / y};
            end
            default: r = x & y;
        endcase
        return {1'b0, 32'd0, r};
    endfunction

    // scoreboard monitor: every done cycle must match the oldest expectation
    always @(posedge clock) begin
        #1;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 65'd1, 65'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", {div_by_zero, result_hi, result_lo}, mon_e);
                last_res = mon_e;
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1;
        start = 1'b1;
        op    = 5'd2;
        repeat (3) @(posedge clock);
        #1;
        check("rst_state", 65'(state_dbg), 65'(ST_IDLE));
        check("rst_busy", 65'(busy), 65'd0);
        check("rst_done", 65'(done), 65'd0);
        check("rst_result", {div_by_zero, result_hi, result_lo}, 65'd0);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Issue one op. inject_at: sample index at which a stray ADD start is
    // driven (must be ignored). abort_at: sample index at which reset is hit.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int inject_at, input int abort_at);
        int k;
        int nbusy;
        int guard;
        bit is_iter;
        logic [64:0] e;
        e       = model(o, x, y);
        is_iter = (o == 5'd7) || (o == 5'd8 && y != 32'd0);
        guard   = 0;
        @(negedge clock);
        while (busy === 1'b1 && guard < 200) begin
            @(negedge clock);
            guard++;
        end
        if (guard >= 200) check("wait_idle_timeout", 65'd1, 65'd0);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        if (abort_at < 0) exp_q.push_back(e);
        @(posedge clock);
        #1;
        start = 1'b0;
        k     = 1;
        nbusy = (busy === 1'b1) ? 1 : 0;
        while (done !== 1'b1 && k < 80 && !(abort_at >= 0 && k == abort_at)) begin
            // scramble inputs after accept; only an injected start is raised
            start = (k == inject_at);
            op    = (k == inject_at) ? OP_ADD : 5'($urandom_range(0, 31));
            a     = $urandom;
            b     = $urandom;
            @(posedge clock);
            #1;
            start = 1'b0;
            k++;
            if (busy === 1'b1) nbusy++;
            if (is_iter && k == 16)
                check($sformatf("hold_op%0d", o), {div_by_zero, result_hi, result_lo}, last_res);
        end
        if (abort_at >= 0) begin
            reset = 1'b1;
            start = 1'b1;
            op    = OP_ADD;
            @(posedge clock);
            #1;
            reset = 1'b0;
            start = 1'b0;
            check("abort_state", 65'(state_dbg), 65'(ST_IDLE));
            check("abort_busy_done", {63'd0, busy, done}, 65'd0);
            check("abort_result", {div_by_zero, result_hi, result_lo}, 65'd0);
            last_res = '0;
            repeat (40) @(posedge clock);
            return;
        end
        if (done !== 1'b1) begin
            check($sformatf("done_timeout_op%0d", o), 65'd0, 65'd1);
        end else begin
            check($sformatf("latency_op%0d", o), 65'(k), is_iter ? 65'd33 : 65'd1);
            check($sformatf("busy_cycles_op%0d", o), 65'(nbusy), is_iter ? 65'd32 : 65'd0);
        end
    endtask

    initial begin
        logic [4:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        reset_dut();

        run_op(5'd2, 32'd5, 32'd7, -1, -1);
        run_op(5'd7, 32'hFFFF_FFFF, 32'd2, -1, -1);
        run_op(5'd8, 32'd100, 32'd7, -1, -1);
        run_op(5'd8, 32'h1234, 32'd0, -1, -1);
        run_op(5'd7, 32'h1234_5678, 32'h9ABC_DEF0, 6, -1);
        run_op(5'd7, 32'hDEAD_BEEF, 32'h0000_1000, -1, 11);
        run_op(5'd2, 32'd3, 32'd4, -1, -1);

        run_op(5'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(5'd8, 32'hFFFF_FFFF, 32'd1, -1, -1);
        run_op(5'd8, 32'd5, 32'd9, -1, -1);
        run_op(5'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(5'd4, 32'd0, 32'd3, -1, -1);
        run_op(5'd4, 32'd1, 32'd3, -1, -1);
        run_op(5'd5, 32'h8000_0001, 32'd0, -1, -1);
        run_op(5'd6, 32'h8000_0001, 32'd0, -1, -1);
        run_op(5'd3, 32'd0, 32'd1, -1, -1);
        run_op(5'd31, 32'hF0F0_F0F0, 32'h3C3C_3C3C, -1, -1);
        run_op(5'd9, 32'hAAAA_5555, 32'hFFFF_0000, -1, -1);
        run_op(5'd0, 32'hAAAA_0000, 32'h0000_5555, -1, -1);

        for (int i = 0; i < 24; i++) begin
            ro = 5'($urandom_range(0, 12));
            if (ro > 5'd8 && $urandom_range(0, 1) == 0) ro = 5'd31;
            rx = $urandom;
            ry = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            if (ro == 5'd8 && $urandom_range(0, 1) == 0) ry = 32'($urandom_range(1, 50));
            run_op(ro, rx, ry, -1, -1);
        end

        repeat (5) @(posedge clock);
        #1;
        check("queue_empty", 65'(exp_q.size()), 65'd0);
        check("final_idle", 65'(state_dbg), 65'(ST_IDLE));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
